// File: rtl/alu_cmd_sequencer.sv
// Command-side driver for the 4-bit ALU accumulator: buffers commands in a FIFO and issues
// them one at a time. Each result is captured after a fixed latency and returned on a response port.
module alu_cmd_sequencer #(
  parameter int WIDTH      = 4,
  parameter int MODE_W     = 4,
  parameter int ALU_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_a,
  input  logic [WIDTH-1:0]  cmd_b,
  input  logic [MODE_W-1:0] cmd_m,
  input  logic              cmd_cin,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [MODE_W-1:0] alu_m,
  output logic              alu_cin,
  output logic              alu_nReset,
  input  logic [WIDTH-1:0]  alu_r,
  input  logic              alu_of,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_r,
  output logic              rsp_of,
  output logic [MODE_W-1:0] rsp_m,
  output logic [7:0]        op_count,
  output logic [7:0]        of_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(ALU_LAT + 1) + 1;
  localparam logic [AW:0]   DEPTH_V = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   FILL_1  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_1   = AW'(1);
  localparam logic [CW-1:0] LAT_V   = CW'(ALU_LAT);
  localparam logic [CW-1:0] CNT_1   = CW'(1);

  typedef struct packed {
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [MODE_W-1:0] m;
    logic              cin;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, state_n;
  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fill;
  logic          full, empty, push, pop;
  logic [CW-1:0] wait_cnt;
  logic          lat_done, accept;

  assign full      = (fill == DEPTH_V);
  assign empty     = (fill == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign lat_done  = (wait_cnt == LAT_V);
  assign accept    = rsp_valid && rsp_ready;

  // NOTE: storage array has no reset; validity is tracked by fill, so clearing it buys nothing.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, m: cmd_m, cin: cmd_cin};
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_1;
      if (pop)  rd_ptr <= rd_ptr + PTR_1;
      unique case ({push, pop})
        2'b10:   fill <= fill + FILL_1;
        2'b01:   fill <= fill - FILL_1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // NOTE: defaults first so no path leaves state_n/pop unassigned, which would infer a latch.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: if (!empty) begin
        pop     = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT:  if (lat_done) state_n = S_RESP;
      S_RESP:  if (accept) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Reset to the accumulator is released one cycle after our own reset goes away.
  always_ff @(posedge Clk) begin
    if (Reset) alu_nReset <= 1'b0;
    else       alu_nReset <= 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_m     <= '0;
      alu_cin   <= 1'b0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_r     <= '0;
      rsp_of    <= 1'b0;
      rsp_m     <= '0;
      op_count  <= '0;
      of_count  <= '0;
    end else begin
      if (pop) begin
        alu_a    <= mem[rd_ptr].a;
        alu_b    <= mem[rd_ptr].b;
        alu_m    <= mem[rd_ptr].m;
        alu_cin  <= mem[rd_ptr].cin;
        wait_cnt <= '0;
      end
      if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + CNT_1;
        if (lat_done) begin
          rsp_r     <= alu_r;
          rsp_of    <= alu_of;
          rsp_m     <= alu_m;
          rsp_valid <= 1'b1;
        end
      end
      if (state == S_RESP && accept) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 8'd1;
        if (rsp_of && of_count != 8'hFF) of_count <= of_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a one-cycle-latency accumulator model
// (mode 0 = a+b+cin with carry as flag, other modes = a^b with cin as flag).
module tb_alu_cmd_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_a, cmd_b, cmd_m;
  logic       cmd_cin;
  logic [3:0] alu_a, alu_b, alu_m;
  logic       alu_cin, alu_nReset;
  logic [3:0] alu_r;
  logic       alu_of;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_r, rsp_m;
  logic       rsp_of;
  logic [7:0] op_count, of_count;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  alu_cmd_sequencer dut (
    .Clk(Clk), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_m(cmd_m), .cmd_cin(cmd_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_nReset(alu_nReset), .alu_r(alu_r), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_of(rsp_of), .rsp_m(rsp_m),
    .op_count(op_count), .of_count(of_count)
  );

  always @(posedge Clk) begin
    if (!alu_nReset) begin
      alu_r  <= 4'h0;
      alu_of <= 1'b0;
    end else if (alu_m == 4'h0) begin
      {alu_of, alu_r} <= alu_a + alu_b + 5'(alu_cin);
    end else begin
      alu_r  <= alu_a ^ alu_b;
      alu_of <= alu_cin;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] m,
                         input logic cin);
    cmd_a   = a;
    cmd_b   = b;
    cmd_m   = m;
    cmd_cin = cin;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(rsp_valid), 1);
  endtask

  // Back-pressure vectors: a, b, m, cin and hand-computed r, of.
  logic [3:0] v_a  [5] = '{4'h3, 4'h9, 4'hA, 4'hC, 4'h6};
  logic [3:0] v_b  [5] = '{4'h4, 4'h8, 4'h5, 4'h3, 4'h6};
  logic [3:0] v_m  [5] = '{4'h0, 4'h0, 4'h2, 4'h3, 4'h1};
  logic       v_ci [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [3:0] v_r  [5] = '{4'h7, 4'h2, 4'hF, 4'hF, 4'h0};
  logic       v_of [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int pushed, resp, n;

    // Reset for two cycles.
    Reset = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    set_cmd(4'h0, 4'h0, 4'h0, 1'b0);
    tick();
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_alu", {alu_a, alu_b, alu_m, 3'b0, alu_cin}, 0);
    check("rst_rsp", {rsp_r, rsp_m, 3'b0, rsp_of}, 0);
    check("rst_counts", {op_count, of_count}, 0);
    check("rst_nreset_low", 32'(alu_nReset), 0);
    Reset = 1'b0;
    tick();
    check("nreset_high", 32'(alu_nReset), 1);

    // Single command F+1: r=0 with carry, response three edges after push.
    set_cmd(4'hF, 4'h1, 4'h0, 1'b0);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("lat_e1", 32'(rsp_valid), 0);
    tick();
    check("lat_e2", 32'(rsp_valid), 0);
    check("issue_a", 32'(alu_a), 32'hF);
    tick();
    check("lat_e3_wait", 32'(rsp_valid), 0);
    tick();
    check("lat_e3", 32'(rsp_valid), 1);
    check("single_r", 32'(rsp_r), 0);
    check("single_of", 32'(rsp_of), 1);
    check("single_m", 32'(rsp_m), 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("single_done", 32'(rsp_valid), 0);
    check("single_op_count", 32'(op_count), 1);
    check("single_of_count", 32'(of_count), 1);

    // Five back-to-back pushes with the consumer stalled.
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_cmd(v_a[i], v_b[i], v_m[i], v_ci[i]);
      tick();
      check($sformatf("bp_cmd_ready_%0d", i), 32'(cmd_ready), (i < 4) ? 1 : 0);
    end
    cmd_valid = 1'b0;

    // Stalled response holds everything stable.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_rsp", {rsp_r, rsp_m, 3'b0, rsp_of}, {4'h7, 4'h0, 4'b0000});
      check("hold_alu", {alu_a, alu_b, alu_m, 3'b0, alu_cin}, {4'h3, 4'h4, 4'h0, 4'b0000});
      check("hold_full", 32'(cmd_ready), 0);
    end

    // Drain in push order.
    rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_rsp($sformatf("drain_%0d", j));
      check($sformatf("drain_r_%0d", j), 32'(rsp_r), 32'(v_r[j]));
      check($sformatf("drain_of_%0d", j), 32'(rsp_of), 32'(v_of[j]));
      check($sformatf("drain_m_%0d", j), 32'(rsp_m), 32'(v_m[j]));
      tick();
      if (j == 0) begin
        tick();
        check("ready_after_pop", 32'(cmd_ready), 1);
      end
    end
    rsp_ready = 1'b0;
    check("drain_op_count", 32'(op_count), 6);
    check("drain_of_count", 32'(of_count), 4);

    // Reset while a command is in WAIT and two more are queued.
    cmd_valid = 1'b1;
    set_cmd(4'h5, 4'h1, 4'h0, 1'b0);
    tick();
    set_cmd(4'h6, 4'h1, 4'h0, 1'b0);
    tick();
    set_cmd(4'h7, 4'h1, 4'h0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("pre_rst_wait", 32'(rsp_valid), 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_counts", {op_count, of_count}, 0);
    check("mid_rst_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mid_rst_no_rsp", 32'(rsp_valid), 0);
    end
    check("mid_rst_fifo_empty", 32'(alu_a), 0);
    check("mid_rst_counts_after", {op_count, of_count}, 0);

    // 300 overflowing commands: op_count wraps, of_count saturates.
    set_cmd(4'hF, 4'h1, 4'h0, 1'b0);
    rsp_ready = 1'b1;
    pushed = 0;
    resp = 0;
    n = 0;
    while (resp < 300 && n < 3000) begin
      cmd_valid = (pushed < 300);
      if (cmd_valid && cmd_ready) pushed++;
      if (rsp_valid) resp++;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    check("bulk_timeout", 32'(resp), 300);
    check("bulk_op_count", 32'(op_count), 44);
    check("bulk_of_count", 32'(of_count), 255);
    check("bulk_idle", 32'(rsp_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
